hazard_ctrl_unit: RTL and testbench

//  Parametrised hazard controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_ctrl_unit_sat_counter.sv | 27 ++
 rtl/hazard_ctrl_unit.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM encoding, hazard classes and per-class stall lengths.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  localparam logic [2:0] HZ_NONE = 3'd0;
  localparam logic [2:0] HZ_LU   = 3'd1;
  localparam logic [2:0] HZ_BALU = 3'd2;
  localparam logic [2:0] HZ_BLD  = 3'd3;
  localparam logic [2:0] HZ_BMEM = 3'd4;

  localparam int unsigned HOLD_CNT_W = 2;

  localparam logic [HOLD_CNT_W-1:0] STALL_LEN_LU   = 2'd1;
  localparam logic [HOLD_CNT_W-1:0] STALL_LEN_BALU = 2'd1;
  localparam logic [HOLD_CNT_W-1:0] STALL_LEN_BLD  = 2'd2;
  localparam logic [HOLD_CNT_W-1:0] STALL_LEN_BMEM = 2'd1;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // count register: cleared by reset/clear, sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: load-use / branch-operand stalls,
// memory-busy freeze, taken-branch IF/ID flush and a saturating stall counter.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 3,
  parameter bit R0_HARDWIRED = 1'b1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic                   id_branch,
  input  logic                   branch_taken,
  input  logic [REG_AW-1:0]      ex_rd,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic [REG_AW-1:0]      mem_rd,
  input  logic                   mem_memread,
  input  logic                   mem_busy,
  output logic                   pc_en,
  output logic                   if2id_en,
  output logic                   if2id_flush,
  output logic                   id2ex_bubble,
  output logic                   ex2mem_en,
  output logic                   mem2wb_en,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  state_e                state_r, state_s, ret_r, ret_s, eff_state_s;
  logic [HOLD_CNT_W-1:0] cnt_r, cnt_s, stall_len_s;
  logic                  ex_match_s, mem_match_s;
  logic [2:0]            hz_class_s;
  logic                  count_s;
  logic [5:0]            outs_s;

  localparam logic [5:0] OUT_NORMAL = 6'b110011;
  localparam logic [5:0] OUT_STALL  = 6'b000111;
  localparam logic [5:0] OUT_FREEZE = 6'b000000;
  localparam logic [5:0] OUT_FLUSH  = 6'b111011;

  function automatic logic reg_match(input logic use_x, input logic [REG_AW-1:0] x,
                                     input logic [REG_AW-1:0] r);
    reg_match = use_x && (x == r) && !(R0_HARDWIRED && (r == {REG_AW{1'b0}}));
  endfunction

  assign ex_match_s  = reg_match(id_use_rs, id_rs, ex_rd)  || reg_match(id_use_rt, id_rt, ex_rd);
  assign mem_match_s = reg_match(id_use_rs, id_rs, mem_rd) || reg_match(id_use_rt, id_rt, mem_rd);

  // hazard classification; a branch on a loaded value outranks plain load-use
  always_comb begin
    hz_class_s  = HZ_NONE;
    stall_len_s = {HOLD_CNT_W{1'b0}};
    if (id_branch && ex_memread && ex_match_s) begin
      hz_class_s  = HZ_BLD;
      stall_len_s = STALL_LEN_BLD;
    end else if (ex_memread && ex_match_s) begin
      hz_class_s  = HZ_LU;
      stall_len_s = STALL_LEN_LU;
    end else if (id_branch && ex_regwrite && ex_match_s) begin
      hz_class_s  = HZ_BALU;
      stall_len_s = STALL_LEN_BALU;
    end else if (id_branch && mem_memread && mem_match_s) begin
      hz_class_s  = HZ_BMEM;
      stall_len_s = STALL_LEN_BMEM;
    end else begin
      hz_class_s  = HZ_NONE;
      stall_len_s = {HOLD_CNT_W{1'b0}};
    end
  end

  // FREEZE behaves as its saved state once mem_busy drops, so a freeze lasts exactly as long as busy
  assign eff_state_s = (state_r == ST_FREEZE) ? ret_r : state_r;

  // next-state and pipeline-control outputs
  always_comb begin
    state_s = state_r;
    ret_s   = ret_r;
    cnt_s   = cnt_r;
    outs_s  = OUT_NORMAL;
    count_s = 1'b0;
    if (rst) begin
      state_s = ST_RUN;
      ret_s   = ST_RUN;
      cnt_s   = {HOLD_CNT_W{1'b0}};
    end else if (mem_busy) begin
      outs_s  = OUT_FREEZE;
      count_s = 1'b1;
      state_s = ST_FREEZE;
      ret_s   = eff_state_s;
    end else begin
      case (eff_state_s)
        ST_HOLD: begin
          outs_s  = OUT_STALL;
          count_s = 1'b1;
          cnt_s   = (cnt_r == {HOLD_CNT_W{1'b0}}) ? cnt_r : cnt_r - 2'd1;
          state_s = (cnt_s == {HOLD_CNT_W{1'b0}}) ? ST_RUN : ST_HOLD;
        end
        ST_RUN: begin
          state_s = ST_RUN;
          case (hz_class_s)
            HZ_LU, HZ_BALU, HZ_BLD, HZ_BMEM: begin
              outs_s  = OUT_STALL;
              count_s = 1'b1;
              if (stall_len_s > 2'd1) begin
                state_s = ST_HOLD;
                cnt_s   = stall_len_s - 2'd1;
              end else begin
                state_s = ST_RUN;
              end
            end
            HZ_NONE: begin
              if (id_branch && branch_taken) begin
                outs_s = OUT_FLUSH;
              end else begin
                outs_s = OUT_NORMAL;
              end
            end
            default: begin
              outs_s  = OUT_STALL;
              count_s = 1'b1;
            end
          endcase
        end
        default: begin
          state_s = ST_RUN;
          ret_s   = ST_RUN;
          cnt_s   = {HOLD_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // FSM state, return state and pending hold count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      ret_r   <= ST_RUN;
      cnt_r   <= {HOLD_CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      ret_r   <= ret_s;
      cnt_r   <= cnt_s;
    end
  end

  assign {pc_en, if2id_en, if2id_flush, id2ex_bubble, ex2mem_en, mem2wb_en} = outs_s;

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (count_s),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit (4-bit stall counter to reach saturation).
module tb_hazard_ctrl_unit;

  localparam int AW = 3;
  localparam int CW = 4;

  localparam logic [5:0] NORMAL = 6'b110011;
  localparam logic [5:0] STALL  = 6'b000111;
  localparam logic [5:0] FREEZE = 6'b000000;
  localparam logic [5:0] FLUSH  = 6'b111011;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic          id_use_rs, id_use_rt, id_branch, branch_taken;
  logic          ex_regwrite, ex_memread, mem_memread, mem_busy;
  logic          pc_en, if2id_en, if2id_flush, id2ex_bubble, ex2mem_en, mem2wb_en;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(AW), .R0_HARDWIRED(1'b1), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .branch_taken(branch_taken),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_memread(mem_memread), .mem_busy(mem_busy),
    .pc_en(pc_en), .if2id_en(if2id_en), .if2id_flush(if2id_flush),
    .id2ex_bubble(id2ex_bubble), .ex2mem_en(ex2mem_en), .mem2wb_en(mem2wb_en),
    .stall_cycles(stall_cycles)
  );

  task automatic idle();
    id_rs = 3'd0; id_rt = 3'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_branch = 1'b0; branch_taken = 1'b0;
    ex_rd = 3'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 3'd0; mem_memread = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    @(negedge clk);
    obs = {pc_en, if2id_en, if2id_flush, id2ex_bubble, ex2mem_en, mem2wb_en};
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: enables got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] exp);
    checks++;
    assert (stall_cycles === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: stall_cycles got %0d expected %0d", tag, stall_cycles, exp);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // reset overrides a live load-use hazard
    ex_memread = 1'b1; ex_rd = 3'd2; id_rs = 3'd2; id_use_rs = 1'b1;
    chk_out("reset_outs", NORMAL);
    tick();
    chk_cnt("reset_cnt", 4'd0);
    rst = 1'b0;

    // lw r2 in EX, add r3=r2+r1 in ID
    id_rt = 3'd1; id_use_rt = 1'b1;
    chk_out("lu_stall", STALL);
    tick();
    ex_memread = 1'b0; ex_rd = 3'd0; mem_memread = 1'b1; mem_rd = 3'd2;
    chk_out("lu_release", NORMAL);
    chk_cnt("lu_cnt", 4'd1);
    tick();

    // load to r0 never hazards
    idle();
    ex_memread = 1'b1; ex_rd = 3'd0; id_rs = 3'd0; id_use_rs = 1'b1; id_use_rt = 1'b1;
    chk_out("r0_no_stall", NORMAL);
    tick();
    chk_cnt("r0_cnt", 4'd1);

    // add r6 in EX, bne r6,r0 taken
    idle();
    ex_regwrite = 1'b1; ex_rd = 3'd6; id_branch = 1'b1; branch_taken = 1'b1;
    id_rs = 3'd6; id_rt = 3'd0; id_use_rs = 1'b1; id_use_rt = 1'b1;
    chk_out("balu_stall", STALL);
    tick();
    ex_regwrite = 1'b0; ex_rd = 3'd0; mem_rd = 3'd6;
    chk_out("balu_flush", FLUSH);
    chk_cnt("balu_cnt", 4'd2);
    tick();
    idle();
    chk_out("after_flush", NORMAL);
    tick();

    // lw r4 in EX, beq r4,r5 taken: two stalls then flush
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 3'd4; id_branch = 1'b1; branch_taken = 1'b1;
    id_rs = 3'd4; id_rt = 3'd5; id_use_rs = 1'b1; id_use_rt = 1'b1;
    chk_out("bld_stall1", STALL);
    tick();
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 3'd0; mem_memread = 1'b1; mem_rd = 3'd4;
    chk_out("bld_hold", STALL);
    chk_cnt("bld_cnt_mid", 4'd3);
    tick();
    mem_memread = 1'b0; mem_rd = 3'd0;
    chk_out("bld_flush", FLUSH);
    chk_cnt("bld_cnt", 4'd4);
    tick();

    // mem_busy for 3 cycles while in HOLD
    idle();
    ex_memread = 1'b1; ex_rd = 3'd4; id_branch = 1'b1; id_rs = 3'd4; id_use_rs = 1'b1;
    chk_out("busy_entry_stall", STALL);
    tick();
    idle();
    mem_busy = 1'b1;
    chk_out("busy_freeze1", FREEZE);
    tick();
    chk_out("busy_freeze2", FREEZE);
    tick();
    chk_out("busy_freeze3", FREEZE);
    tick();
    mem_busy = 1'b0;
    chk_out("busy_hold_resume", STALL);
    tick();
    chk_out("busy_back_run", NORMAL);
    chk_cnt("busy_cnt", 4'd9);
    tick();

    // freeze beats a taken-branch flush
    id_branch = 1'b1; branch_taken = 1'b1; mem_busy = 1'b1;
    chk_out("freeze_over_flush", FREEZE);
    tick();
    mem_busy = 1'b0;
    chk_out("flush_after_freeze", FLUSH);
    chk_cnt("freeze_cnt", 4'd10);
    tick();

    // saturation: 8 more stall cycles from 10 must stick at 15
    idle();
    ex_memread = 1'b1; ex_rd = 3'd3; id_rt = 3'd3; id_use_rt = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk_out("sat_still_stall", STALL);
    chk_cnt("sat_cnt", 4'd15);
    tick();

    // reset in the middle of HOLD
    idle();
    ex_memread = 1'b1; ex_rd = 3'd4; id_branch = 1'b1; id_rs = 3'd4; id_use_rs = 1'b1;
    chk_out("rst_hold_entry", STALL);
    tick();
    rst = 1'b1;
    chk_out("rst_mid_hold", NORMAL);
    tick();
    rst = 1'b0;
    idle();
    chk_out("rst_back_run", NORMAL);
    chk_cnt("rst_cnt_clear", 4'd0);
    tick();
    ex_memread = 1'b1; ex_rd = 3'd5; id_rs = 3'd5; id_use_rs = 1'b1;
    chk_out("post_rst_lu", STALL);
    tick();
    idle();
    chk_out("post_rst_run", NORMAL);
    chk_cnt("post_rst_cnt", 4'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
